// File: rtl/iso14443a_miller_tx.sv
// ---------------------------------------------------------------------------
// iso14443a_miller_tx
//
// Reader-to-tag frame encoder for ISO14443-A. Takes bytes from the ARM-side
// byte interface, adds SOF, odd parity and EOF, and drives the Modified
// Miller pause pattern on mod_sig_coil (1 = carrier off). Runs on the
// 13.56 MHz carrier, all state on the falling edge like the rest of the HF
// datapath.
//
// Ports
//   ck_1356meg    carrier clock (negedge active)
//   rst           synchronous, active-high reset
//   in_data       byte to send, LSB first
//   in_valid      byte offered
//   in_ready      byte taken on a cycle with in_valid & in_ready
//   in_last       accepted byte is the final byte of the frame
//   in_short      first byte only: 7-bit short frame (REQA/WUPA), no parity
//   mod_sig_coil  registered pause request
//   busy          frame in flight (acceptance .. done)
//   done          one-cycle pulse on the last tick of the EOF
//   err_underrun  one-cycle pulse when a non-last byte had no successor
// ---------------------------------------------------------------------------
module iso14443a_miller_tx #(
    parameter int PAUSE_LEN = 32    // pause width in carrier ticks, 1..63
) (
    input  logic       ck_1356meg,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_last,
    input  logic       in_short,
    output logic       mod_sig_coil,
    output logic       busy,
    output logic       done,
    output logic       err_underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_DATA,
        S_PARITY,
        S_EOF0,
        S_EOF_Y
    } state_t;

    typedef enum logic [1:0] {
        SYM_NONE,
        SYM_X,
        SYM_Y,
        SYM_Z
    } sym_t;

    // Pause windows inside a 128-tick slot. With PAUSE_LEN <= 63 the X
    // window ends by tick 127, so no pause crosses a slot boundary.
    localparam logic [6:0] Z_END = 7'(PAUSE_LEN);
    localparam logic [6:0] X_BEG = 7'd64;
    localparam logic [6:0] X_END = 7'(64 + PAUSE_LEN);

    state_t     state;
    logic [6:0] tick;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_bit;
    logic       prev_bit;
    logic       cur_last;
    logic       cur_short;

    // Next byte captured during the PARITY slot.
    logic       nxt_valid;
    logic [7:0] nxt_data;
    logic       nxt_last;

    logic       slot_end;
    logic       accept;
    logic [2:0] last_bit_idx;
    logic       cur_bit;
    sym_t       sym;
    logic       pause_now;

    assign slot_end     = (tick == 7'd127);
    assign accept       = in_valid & in_ready;
    assign last_bit_idx = cur_short ? 3'd6 : 3'd7;

    // Ready drops once a follow-on byte is held so a continuously offered
    // stream is taken exactly once per PARITY slot.
    always_comb begin
        in_ready = (state == S_IDLE) ||
                   (state == S_PARITY && !cur_last && !nxt_valid);
    end

    // Symbol for the slot currently being emitted.
    always_comb begin
        cur_bit = 1'b0;
        sym     = SYM_NONE;
        case (state)
            S_SOF:    sym     = SYM_Z;
            S_DATA:   cur_bit = shreg[0];
            S_PARITY: cur_bit = par_bit;
            S_EOF0:   cur_bit = 1'b0;
            S_EOF_Y:  sym     = SYM_Y;
            default:  sym     = SYM_NONE;
        endcase
        if (state == S_DATA || state == S_PARITY || state == S_EOF0) begin
            if (cur_bit)
                sym = SYM_X;
            else
                sym = prev_bit ? SYM_Y : SYM_Z;
        end
    end

    always_comb begin
        case (sym)
            SYM_Z:   pause_now = (tick < Z_END);
            SYM_X:   pause_now = (tick >= X_BEG) && (tick < X_END);
            default: pause_now = 1'b0;
        endcase
    end

    // mod_sig_coil is registered from the current state/tick, so the pause
    // for slot tick 0 of SOF appears on the edge after byte acceptance.
    always_ff @(negedge ck_1356meg) begin
        if (rst) begin
            state        <= S_IDLE;
            tick         <= 7'd0;
            bit_cnt      <= 3'd0;
            shreg        <= 8'd0;
            par_bit      <= 1'b0;
            prev_bit     <= 1'b0;
            cur_last     <= 1'b0;
            cur_short    <= 1'b0;
            nxt_valid    <= 1'b0;
            nxt_data     <= 8'd0;
            nxt_last     <= 1'b0;
            mod_sig_coil <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            mod_sig_coil <= pause_now;
            done         <= 1'b0;
            err_underrun <= 1'b0;

            // Free-running 7-bit slot counter; wraps to 0 at every slot start.
            if (state != S_IDLE)
                tick <= tick + 7'd1;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shreg     <= in_data;
                        par_bit   <= ~^in_data;
                        cur_last  <= in_last | in_short;
                        cur_short <= in_short;
                        prev_bit  <= 1'b0;
                        bit_cnt   <= 3'd0;
                        tick      <= 7'd0;
                        busy      <= 1'b1;
                        state     <= S_SOF;
                    end
                end

                S_SOF: begin
                    if (slot_end) begin
                        prev_bit <= 1'b0;
                        state    <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (slot_end) begin
                        prev_bit <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == last_bit_idx) begin
                            bit_cnt <= 3'd0;
                            state   <= cur_short ? S_EOF0 : S_PARITY;
                        end
                    end
                end

                S_PARITY: begin
                    if (accept) begin
                        nxt_valid <= 1'b1;
                        nxt_data  <= in_data;
                        nxt_last  <= in_last;
                    end
                    if (slot_end) begin
                        prev_bit  <= par_bit;
                        nxt_valid <= 1'b0;
                        // A byte taken on the slot-end edge itself goes
                        // straight into the shifter.
                        if (nxt_valid || accept) begin
                            shreg    <= nxt_valid ? nxt_data : in_data;
                            par_bit  <= nxt_valid ? ~^nxt_data : ~^in_data;
                            cur_last <= nxt_valid ? nxt_last : in_last;
                            state    <= S_DATA;
                        end else begin
                            if (!cur_last)
                                err_underrun <= 1'b1;
                            state <= S_EOF0;
                        end
                    end
                end

                S_EOF0: begin
                    if (slot_end)
                        state <= S_EOF_Y;
                end

                S_EOF_Y: begin
                    if (slot_end) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iso14443a_miller_tx.sv
// Bench for iso14443a_miller_tx: two instances (PAUSE_LEN 32 and 63) share
// all inputs; a symbol-level model predicts the pause waveform, handshake
// timing, done/err_underrun offsets and busy length for each frame.
module tb_iso14443a_miller_tx;

    logic       ck_1356meg = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid, in_last, in_short;
    logic       rdy32, mod32, busy32, done32, err32;
    logic       rdy63, mod63, busy63, done63, err63;

    always #5 ck_1356meg = ~ck_1356meg;

    iso14443a_miller_tx #(.PAUSE_LEN(32)) dut32 (
        .ck_1356meg(ck_1356meg), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy32), .in_last(in_last), .in_short(in_short),
        .mod_sig_coil(mod32), .busy(busy32), .done(done32), .err_underrun(err32));

    iso14443a_miller_tx #(.PAUSE_LEN(63)) dut63 (
        .ck_1356meg(ck_1356meg), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy63), .in_last(in_last), .in_short(in_short),
        .mod_sig_coil(mod63), .busy(busy63), .done(done63), .err_underrun(err63));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int SY = 0, SX = 1, SZ = 2;

    logic [7:0] fr_bytes[$];
    int         fr_offer[$];   // tick within the preceding PARITY slot where byte i is first offered
    int         fr_edges[$];   // optional expected pause rising edges (PAUSE_LEN 32)
    bit         fr_short, fr_underrun, fr_hold;
    int         fr_abort;      // offset at which reset is asserted, -2 = none
    int         syms[$];
    logic       obs_m32[8192];
    logic       obs_m63[8192];

    function automatic int enc(input bit b, input bit prev);
        return b ? SX : (prev ? SY : SZ);
    endfunction

    function automatic bit exp_pause(input int sym, input int t, input int pl);
        if (sym == SZ) return t < pl;
        if (sym == SX) return (t >= 64) && (t < 64 + pl);
        return 1'b0;
    endfunction

    task automatic build_model(output int nb);
        bit         prev;
        bit         p;
        logic [7:0] v;
        prev = 1'b0;
        syms.delete();
        syms.push_back(SZ);
        nb = fr_short ? 1 : fr_bytes.size();
        for (int i = 0; i < nb; i++) begin
            v = fr_bytes[i];
            for (int b = 0; b < (fr_short ? 7 : 8); b++) begin
                syms.push_back(enc(v[b], prev));
                prev = v[b];
            end
            if (!fr_short) begin
                p = ~^v;
                syms.push_back(enc(p, prev));
                prev = p;
            end
        end
        syms.push_back(enc(1'b0, prev));
        syms.push_back(SY);
    endtask

    task automatic new_frame(input bit sh, input bit ur, input bit hold);
        fr_bytes.delete();
        fr_offer.delete();
        fr_edges.delete();
        fr_short    = sh;
        fr_underrun = ur;
        fr_hold     = hold;
        fr_abort    = -2;
    endtask

    task automatic add_byte(input logic [7:0] b, input int offer);
        fr_bytes.push_back(b);
        fr_offer.push_back(offer);
    endtask

    // ---------------- frame driver / checker ----------------
    task automatic run_frame(input string name);
        int   nb, len, next_i, acc_slot, rdy_bad, ctl_bad;
        int   done_n, done_at, err_n, err_at, busy_n, s, exp_acc;
        bit   exp_rdy, slot_rdy;
        logic prev_m;
        int   acc_q[$];
        int   edges[$];
        logic [127:0] op32, op63, ep32, ep63;

        build_model(nb);
        len = syms.size() * 128;
        next_i = 0; acc_slot = -2; rdy_bad = 0; ctl_bad = 0;
        done_n = 0; done_at = -1; err_n = 0; err_at = -1; busy_n = 0;

        for (int k = -1; k < len; k++) begin
            s = (k < 0) ? -1 : k / 128;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            in_short = 1'($urandom);
            in_valid = 1'b0;
            if (k == -1) begin
                in_valid = 1'b1;
                in_data  = fr_bytes[0];
                in_last  = fr_short ? 1'($urandom) : (nb == 1 && !fr_underrun);
                in_short = fr_short;
            end else if (next_i < nb && (fr_hold || k >= 128 * 9 * next_i + fr_offer[next_i])) begin
                in_valid = 1'b1;
                in_data  = fr_bytes[next_i];
                in_last  = (next_i == nb - 1) && !fr_underrun;
            end else if (fr_hold) begin
                in_valid = 1'b1;
            end

            if (k < 0) begin
                exp_rdy = 1'b1;
            end else begin
                slot_rdy = !fr_short && s >= 9 && (s % 9 == 0) &&
                           ((s / 9 < nb) || (fr_underrun && s / 9 == nb));
                exp_rdy = slot_rdy && (acc_slot != s);
            end
            if (rdy32 !== exp_rdy || rdy63 !== exp_rdy) rdy_bad++;
            if (in_valid && rdy32) begin
                acc_q.push_back(k);
                next_i++;
                acc_slot = s;
            end
            if (k == fr_abort) rst = 1'b1;

            @(negedge ck_1356meg); #1;

            if (k == fr_abort) begin
                chk({name, " pre_rst_pause"}, 128'(obs_m32[k-1]), 128'(1));
                chk({name, " rst_mod32"}, 128'(mod32), 128'(0));
                chk({name, " rst_mod63"}, 128'(mod63), 128'(0));
                chk({name, " rst_busy"}, 128'(busy32), 128'(0));
                chk({name, " rst_done"}, 128'(done32), 128'(0));
                chk({name, " rst_err"}, 128'(err32), 128'(0));
                chk({name, " rst_rdy"}, 128'(rdy32), 128'(1));
                rst = 1'b0;
                in_valid = 1'b0;
                return;
            end
            if (k >= 0) begin
                obs_m32[k] = mod32;
                obs_m63[k] = mod63;
            end
            if (done32) begin done_n++; if (done_at < 0) done_at = k; end
            if (err32)  begin err_n++;  if (err_at < 0)  err_at = k;  end
            if (busy32) busy_n++;
            if (done63 !== done32 || err63 !== err32 || busy63 !== busy32) ctl_bad++;
        end
        in_valid = 1'b0;

        for (int sl = 0; sl < syms.size(); sl++) begin
            for (int tt = 0; tt < 128; tt++) begin
                op32[tt] = obs_m32[sl*128 + tt];
                op63[tt] = obs_m63[sl*128 + tt];
                ep32[tt] = exp_pause(syms[sl], tt, 32);
                ep63[tt] = exp_pause(syms[sl], tt, 63);
            end
            chk($sformatf("%s mod32 slot%0d", name, sl), op32, ep32);
            chk($sformatf("%s mod63 slot%0d", name, sl), op63, ep63);
        end

        chk({name, " done_at"}, 128'(done_at), 128'(len - 1));
        chk({name, " done_cnt"}, 128'(done_n), 128'(1));
        chk({name, " busy_len"}, 128'(busy_n), 128'(len));
        chk({name, " err_cnt"}, 128'(err_n), 128'(fr_underrun ? 1 : 0));
        if (fr_underrun)
            chk({name, " err_at"}, 128'(err_at), 128'(128 * (9 * nb + 1) - 1));
        chk({name, " acc_cnt"}, 128'(acc_q.size()), 128'(nb));
        for (int i = 0; i < acc_q.size() && i < nb; i++) begin
            exp_acc = (i == 0) ? -1 : 128 * 9 * i + (fr_hold ? 0 : fr_offer[i]);
            chk($sformatf("%s acc%0d_at", name, i), 128'(acc_q[i]), 128'(exp_acc));
        end
        chk({name, " rdy_mis"}, 128'(rdy_bad), 128'(0));
        chk({name, " ctl63_mis"}, 128'(ctl_bad), 128'(0));
        chk({name, " idle_rdy"}, 128'(rdy32), 128'(1));
        chk({name, " idle_busy"}, 128'(busy32), 128'(0));

        if (fr_edges.size() > 0) begin
            prev_m = 1'b0;
            for (int k = 0; k < len; k++) begin
                if (obs_m32[k] && !prev_m) edges.push_back(k);
                prev_m = obs_m32[k];
            end
            chk({name, " n_edges"}, 128'(edges.size()), 128'(fr_edges.size()));
            for (int i = 0; i < edges.size() && i < fr_edges.size(); i++)
                chk($sformatf("%s edge%0d", name, i), 128'(edges[i]), 128'(fr_edges[i]));
        end
    endtask

    task automatic reqa_frame(input string name);
        new_frame(1'b1, 1'b0, 1'b0);
        add_byte(8'h26, 0);
        fr_edges = '{0, 128, 320, 448, 640, 832, 1024};
        run_frame(name);
    endtask

    int nb_r, pick;
    bit sh_r, ur_r;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_short = 1'b0;
        repeat (3) @(negedge ck_1356meg);
        #1;
        chk("reset_mod", 128'(mod32), 128'(0));
        chk("reset_mod63", 128'(mod63), 128'(0));
        chk("reset_busy", 128'(busy32), 128'(0));
        chk("reset_done", 128'(done32), 128'(0));
        chk("reset_err", 128'(err32), 128'(0));
        chk("reset_rdy", 128'(rdy32), 128'(1));
        rst = 1'b0;

        reqa_frame("reqa");

        new_frame(1'b0, 1'b0, 1'b0);
        add_byte(8'h93, 0);
        add_byte(8'h20, int'($urandom_range(0, 127)));
        run_frame("two_byte");

        new_frame(1'b0, 1'b1, 1'b0);
        add_byte(8'h93, 0);
        run_frame("underrun");

        new_frame(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) add_byte(8'($urandom), 0);
        run_frame("backpressure");

        new_frame(1'b0, 1'b0, 1'b0);
        add_byte(8'hFF, 0);
        run_frame("ff_last");

        new_frame(1'b0, 1'b0, 1'b0);
        add_byte(8'hFF, 0);
        fr_abort = 3 * 128 + 70;
        run_frame("abort");

        reqa_frame("reqa_after_rst");

        for (int r = 0; r < 6; r++) begin
            nb_r = int'($urandom_range(1, 3));
            sh_r = ($urandom_range(0, 4) == 0);
            ur_r = !sh_r && ($urandom_range(0, 3) == 0);
            new_frame(sh_r, ur_r, ($urandom_range(0, 3) == 0));
            for (int i = 0; i < nb_r; i++) begin
                pick = int'($urandom_range(0, 2));
                add_byte(8'($urandom), (pick == 0) ? 0 : (pick == 1) ? 127 : int'($urandom_range(0, 127)));
            end
            run_frame($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
